clahe_coord_counter: RTL and testbench

Pixel-stream coordinate tracker for the 64-tile CLAHE pipeline. It counts the column and row of every pixel in an HREF/VSYNC video stream and maps each pixel to its tile in an 8×8 grid. Per pixel it outputs the tile index and the pixel's position inside that tile. It sits at the front of the pipeline and feeds the histogram and mapping stages.

---
 rtl/clahe_coord_counter.sv | 60 ++++++
 tb/tb_clahe_coord_counter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/clahe_coord_counter.sv
// clahe_coord_counter: tracks pixel column/row of an HREF/VSYNC stream and maps each pixel to its tile in the CLAHE grid
module clahe_coord_counter #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int TILE_H_NUM = 8,
  parameter int TILE_V_NUM = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        in_href,
  input  logic        in_vsync,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic [2:0]  tile_x,
  output logic [2:0]  tile_y,
  output logic [5:0]  tile_idx,
  output logic [7:0]  local_x,
  output logic [6:0]  local_y
);
  localparam int TW = WIDTH / TILE_H_NUM;
  localparam int TH = HEIGHT / TILE_V_NUM;
  logic        href_d, vsync_d;
  logic [10:0] base_x;
  logic [9:0]  base_y;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      href_d  <= in_href;
      vsync_d <= in_vsync;
      x_cnt   <= (!in_href || x_cnt == 11'(WIDTH - 1)) ? '0 : x_cnt + 11'd1;
      y_cnt   <= (in_vsync && !vsync_d) ? '0 :
                 (!in_href && href_d) ? ((y_cnt == 10'(HEIGHT - 1)) ? '0 : y_cnt + 10'd1) :
                 y_cnt;
    end
  end
  // comparator chain against tile boundaries; the last boundary passed sets tile and base
  always_comb begin
    tile_x = '0;
    base_x = '0;
    tile_y = '0;
    base_y = '0;
    for (int i = 1; i < TILE_H_NUM; i++)
      if (x_cnt >= 11'(i * TW)) begin
        tile_x = 3'(i);
        base_x = 11'(i * TW);
      end
    for (int i = 1; i < TILE_V_NUM; i++)
      if (y_cnt >= 10'(i * TH)) begin
        tile_y = 3'(i);
        base_y = 10'(i * TH);
      end
  end
  assign tile_idx = {tile_y, tile_x};
  assign local_x  = 8'(x_cnt - base_x);
  assign local_y  = 7'(y_cnt - base_y);
endmodule

// File: tb/tb_clahe_coord_counter.sv
// tb_clahe_coord_counter: randomized line/frame stimulus checked against pixel/line indices of the generator
module tb_clahe_coord_counter;
  localparam int W  = 1280;
  localparam int H  = 720;
  localparam int TW = W / 8;
  localparam int TH = H / 8;
  logic        pclk = 1'b0;
  logic        rst, in_href, in_vsync;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic [2:0]  tile_x, tile_y;
  logic [5:0]  tile_idx;
  logic [7:0]  local_x;
  logic [6:0]  local_y;
  logic        vs = 1'b0;
  int          vecs = 0;
  int          errs = 0;
  int          line = 0;

  clahe_coord_counter dut (
    .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .tile_x(tile_x), .tile_y(tile_y),
    .tile_idx(tile_idx), .local_x(local_x), .local_y(local_y)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic h, input logic v);
    @(negedge pclk);
    in_href  = h;
    in_vsync = v;
    #1;
  endtask

  task automatic check_px(input int x, input int y);
    check("x_cnt", int'(x_cnt), x);
    check("y_cnt", int'(y_cnt), y);
    check("tile_x", int'(tile_x), x / TW);
    check("tile_y", int'(tile_y), y / TH);
    check("tile_idx", int'(tile_idx), (y / TH) * 8 + x / TW);
    check("local_x", int'(local_x), x % TW);
    check("local_y", int'(local_y), y % TH);
  endtask

  task automatic run_line(input int len, input int gap, input bit vrise);
    for (int p = 0; p < len; p++) begin
      step(1'b1, vs);
      check_px(p % W, line % H);
    end
    for (int g = 0; g < gap; g++) begin
      if (g == 0 && vrise) vs = 1'b1;
      step(1'b0, vs);
      if (g >= 1) check_px(0, vrise ? 0 : (line + 1) % H);
    end
    line = vrise ? 0 : line + 1;
  endtask

  task automatic new_frame();
    vs = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    vs = 1'b1;
    step(1'b0, 1'b1);
    line = 0;
  endtask

  initial begin
    rst = 1'b1;
    in_href = 1'b0;
    in_vsync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check_px(0, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_px(0, 0);
    end
    new_frame();
    for (int l = 0; l < H + 1; l++) begin
      int len;
      len = (l == 0 || l == H - 1) ? W :
            (l == 300) ? W + 3 :
            (l == 89 || l == 90) ? 200 : int'($urandom_range(1, 8));
      run_line(len, int'($urandom_range(11, 14)), 1'b0);
    end
    new_frame();
    for (int l = 0; l < 3; l++) run_line(int'($urandom_range(1, 6)), 12, 1'b0);
    vs = 1'b0;
    run_line(int'($urandom_range(2, 6)), 12, 1'b1);
    run_line(4, 11, 1'b0);
    for (int p = 0; p < 10; p++) begin
      step(1'b1, vs);
      check_px(p, line % H);
    end
    #2 rst = 1'b1;
    #1 check_px(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, vs);
      check_px(0, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, vs);
      check_px(0, 0);
    end
    line = 0;
    run_line(20, 11, 1'b0);
    run_line(int'($urandom_range(1, 6)), 11, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
